axis_pkt_gen: RTL
=================

AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: m_tdata width in bits; legal values are 8, 16 and 32.
REQ-002 SHALL have parameter LBITS, default 11: width of the packet-length field, in beats.
REQ-003 SHALL have parameter CBITS, default 16: width of the packet-count limit and of the sent-packet counter.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous reset, active-high.
REQ-006 SHALL have port enable_i, input, 1 bit: run request.
REQ-007 SHALL have port mode_i, input, 2 bits: data pattern select.
REQ-008 SHALL have port length_i, input, LBITS bits: beats per packet.
REQ-009 SHALL have port gap_i, input, 8 bits: idle cycles between packets.
REQ-010 SHALL have port limit_i, input, CBITS bits: packets per run; 0 means unlimited.
REQ-011 SHALL have ports m_tvalid_o (output, 1), m_tready_i (input, 1), m_tlast_o (output, 1), m_tkeep_o (output, 1) and m_tdata_o (output, WIDTH): the AXI4-Stream source.
REQ-012 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port done_o, output, 1 bit: high while in DONE.
REQ-014 SHALL have port count_o, output, CBITS bits: packets completed in the current run.

Function
REQ-015 SHALL implement the states IDLE, SEND, GAP and DONE.
REQ-016 IDLE->SEND SHALL occur on the cycle after enable_i is sampled high.
- On that transition: latch mode_i, length_i, gap_i and limit_i; clear count_o.
REQ-017 Latched values SHALL be used for the whole run; input changes during a run SHALL be ignored.
REQ-018 m_tvalid_o SHALL be high in SEND and low in all other states.
REQ-019 While m_tvalid_o is high and m_tready_i is low, m_tdata_o, m_tlast_o and m_tkeep_o SHALL hold stable.
REQ-020 A beat SHALL transfer on each cycle with m_tvalid_o and m_tready_i both high.
REQ-021 Throughput SHALL be one beat per cycle when m_tready_i is held high.
REQ-022 For latched length L>=1: m_tlast_o SHALL be high on beat L-1 only, and m_tkeep_o SHALL be 1 on every beat.
REQ-023 For L=0: each packet SHALL be one beat with m_tlast_o=1, m_tkeep_o=0 and m_tdata_o=0 (a zero-length packet).
REQ-024 Pattern mode 0 SHALL output a free-running counter: it starts at 0 at run start, increments by 1 per transferred beat (mod 2^WIDTH) and continues across packets; ZLP beats do not advance it.
REQ-025 Pattern mode 1 SHALL output the low WIDTH bits of a 32-bit Galois LFSR.
- Polynomial 0x80200003; seed 0xFFFFFFFF at run start.
- Advances once per transferred non-ZLP beat.
REQ-026 Pattern mode 2 SHALL output a constant: 0xA5 replicated to WIDTH bits.
REQ-027 Pattern mode 3 SHALL output the beat index within the packet: 0..L-1, zero-extended or truncated to WIDTH bits.
REQ-028 On the tlast handshake, count_o SHALL increment, wrapping mod 2^CBITS.
REQ-029 After the tlast handshake, the next state SHALL be:
- DONE, if limit != 0 and the new count equals limit;
- otherwise IDLE, if enable_i is low;
- otherwise GAP, if gap > 0;
- otherwise SEND.
REQ-030 With gap = 0, the first beat of the next packet SHALL be offered on the cycle immediately after the tlast handshake (no bubble).
REQ-031 GAP SHALL last exactly gap cycles, then go to SEND, or to IDLE if enable_i is low on the final GAP cycle.
REQ-032 Deasserting enable_i mid-packet SHALL NOT truncate the packet: the packet completes and then REQ-029 applies.
REQ-033 DONE SHALL hold until enable_i is sampled low, then go to IDLE; count_o SHALL hold its value in DONE and IDLE.
REQ-034 A tlast handshake and an enable_i fall in the same cycle SHALL resolve per REQ-029, with DONE taking priority.

Reset
REQ-035 While reset is high, the block SHALL be in IDLE with all outputs 0: m_tvalid_o, m_tlast_o, m_tkeep_o, m_tdata_o, busy_o, done_o and count_o.
REQ-036 A reset mid-packet SHALL abort the packet immediately, with no completion beat; after reset release, the block SHALL wait for enable_i.

Verification
REQ-037 Test: mode 0, L=4, gap=0, limit=2, m_tready_i always high -> data 00,01,02,03 | 04,05,06,07 on consecutive cycles; tlast on beats 3 and 7; count_o=2; done_o=1.
REQ-038 Test: mode 3, L=3, gap=2, m_tready_i toggling 1,0 -> data 0,1,2 per packet, held stable through stalls; exactly 2 invalid cycles between packets.
REQ-039 Test: L=0, limit=3 -> three single-beat packets with tkeep=0 and tlast=1; count_o=3; DONE.
REQ-040 Test: mode 1, WIDTH=32, L=2 -> beat values match a reference-model LFSR (seed 0xFFFFFFFF, poly 0x80200003) for 100 packets.
REQ-041 Test: enable_i dropped on beat 1 of an L=8 packet -> beats 1 to 7 still sent with tlast on beat 7; then IDLE with busy_o=0.
REQ-042 Test: reset asserted on beat 2 of a packet -> all outputs 0 asynchronously; after release with enable_i held high, a new run starts with data 00 and count_o=0.

Source files
------------

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator.
// Sends runs of fixed-length packets with a selectable data pattern, an
// optional idle gap between packets and an optional packet-count limit.
// Configuration is captured when a run starts and held for the whole run.
module axis_pkt_gen #(
  parameter int WIDTH = 8,
  parameter int LBITS = 11,
  parameter int CBITS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [1:0]       mode_i,
  input  logic [LBITS-1:0] length_i,
  input  logic [7:0]       gap_i,
  input  logic [CBITS-1:0] limit_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic             m_tkeep_o,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CBITS-1:0] count_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [31:0]      LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0]      LFSR_SEED = 32'hFFFF_FFFF;
  localparam logic [WIDTH-1:0] CONST_PAT = {(WIDTH / 8){8'hA5}};

  localparam logic [1:0] MODE_COUNTER = 2'd0;
  localparam logic [1:0] MODE_LFSR    = 2'd1;
  localparam logic [1:0] MODE_CONST   = 2'd2;

  // Run state and the configuration captured at run start.
  state_t           state_q,   state_d;
  logic [1:0]       mode_q,    mode_d;
  logic [LBITS-1:0] len_q,     len_d;
  logic [7:0]       gap_q,     gap_d;
  logic [CBITS-1:0] limit_q,   limit_d;

  // Progress counters and pattern sources.
  logic [CBITS-1:0] count_q,   count_d;
  logic [LBITS-1:0] beat_q,    beat_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] ctr_q,     ctr_d;
  logic [31:0]      lfsr_q,    lfsr_d;

  // Helper terms shared by the next-state and output logic.
  logic             xfer;
  logic             is_zlp;
  logic             is_last;
  logic [CBITS-1:0] count_inc;
  logic [31:0]      lfsr_step;
  logic             limit_hit;

  // Decode the current beat: handshake, zero-length packet and end-of-packet.
  always_comb begin
    xfer      = (state_q == ST_SEND) && m_tready_i;
    is_zlp    = (len_q == '0);
    is_last   = is_zlp || (beat_q == (len_q - 1'b1));
    count_inc = count_q + 1'b1;
    lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
    limit_hit = (limit_q != '0) && (count_inc == limit_q);
  end

  // Next-state logic: run start, beat advance, packet completion and gap timing.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    gap_d     = gap_q;
    limit_d   = limit_q;
    count_d   = count_q;
    beat_d    = beat_q;
    gap_cnt_d = gap_cnt_q;
    ctr_d     = ctr_q;
    lfsr_d    = lfsr_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_SEND;
          mode_d  = mode_i;
          len_d   = length_i;
          gap_d   = gap_i;
          limit_d = limit_i;
          count_d = '0;
          beat_d  = '0;
          ctr_d   = '0;
          lfsr_d  = LFSR_SEED;
        end
      end

      ST_SEND: begin
        if (xfer) begin
          // Zero-length packets carry no payload, so the pattern sources stay put.
          if (!is_zlp) begin
            ctr_d  = ctr_q + 1'b1;
            lfsr_d = lfsr_step;
          end
          if (is_last) begin
            beat_d    = '0;
            count_d   = count_inc;
            gap_cnt_d = gap_q;
            // Reaching the limit wins over everything, even a falling enable.
            if (limit_hit) begin
              state_d = ST_DONE;
            end else if (!enable_i) begin
              state_d = ST_IDLE;
            end else if (gap_q != 8'd0) begin
              state_d = ST_GAP;
            end else begin
              state_d = ST_SEND;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        // The counter is loaded with the gap length, so the cycle that sees 1
        // is the last idle cycle and decides whether the run continues.
        if (gap_cnt_q <= 8'd1) begin
          state_d = enable_i ? ST_SEND : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      ST_DONE: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops straight back to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= 2'd0;
      len_q     <= '0;
      gap_q     <= 8'd0;
      limit_q   <= '0;
      count_q   <= '0;
      beat_q    <= '0;
      gap_cnt_q <= 8'd0;
      ctr_q     <= '0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      limit_q   <= limit_d;
      count_q   <= count_d;
      beat_q    <= beat_d;
      gap_cnt_q <= gap_cnt_d;
      ctr_q     <= ctr_d;
      lfsr_q    <= lfsr_d;
    end
  end

  // Stream and status outputs; payload is forced to zero outside SEND.
  always_comb begin
    m_tvalid_o = (state_q == ST_SEND);
    busy_o     = (state_q != ST_IDLE);
    done_o     = (state_q == ST_DONE);
    count_o    = count_q;
    m_tlast_o  = 1'b0;
    m_tkeep_o  = 1'b0;
    m_tdata_o  = '0;

    if (state_q == ST_SEND) begin
      m_tlast_o = is_last;
      m_tkeep_o = !is_zlp;
      if (!is_zlp) begin
        case (mode_q)
          MODE_COUNTER: m_tdata_o = ctr_q;
          MODE_LFSR:    m_tdata_o = lfsr_q[WIDTH-1:0];
          MODE_CONST:   m_tdata_o = CONST_PAT;
          default:      m_tdata_o = WIDTH'(beat_q);
        endcase
      end
    end
  end

endmodule
